// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl -- iterative multiply/divide unit (MULT, MULTU, DIV, DIVU)
//
// Multiply is a 32-step shift-add on operand magnitudes; divide is a 32-step
// restoring divider on magnitudes. Signs are reapplied when the unit enters
// DONE, which is also the only time md_hi/md_lo change.
//
// Build option:
//   MD_CTRL_DIV_EN  defined   -> divider datapath present
//                   undefined -> DIV/DIVU finish on the next edge with 0/0
//
// Parameters:
//   ZERO_DIV_Q  quotient (md_lo) returned on divide-by-zero
//
// Ports:
//   clk        in   clock, all state changes on rising edge
//   resetn     in   asynchronous active-low reset
//   md_start   in   start request
//   md_op      in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   md_src1    in   32 multiplicand / dividend
//   md_src2    in   32 multiplier / divisor
//   md_cancel  in   abort current operation (wins over md_start)
//   md_ready   out  start can be accepted this cycle
//   md_busy    out  operation in progress
//   md_done    out  one-cycle completion pulse
//   md_hi      out  32 product[63:32] or remainder
//   md_lo      out  32 product[31:0] or quotient
// -----------------------------------------------------------------------------
module md_ctrl #(
   parameter logic [31:0] ZERO_DIV_Q = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        md_start,
   input  logic [1:0]  md_op,
   input  logic [31:0] md_src1,
   input  logic [31:0] md_src2,
   input  logic        md_cancel,
   output logic        md_ready,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] md_hi,
   output logic [31:0] md_lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        accept;

   // prod_q holds {accumulator/remainder, multiplier/quotient}; opb_q holds
   // the multiplicand or divisor magnitude.
   logic [63:0] prod_q, prod_nxt;
   logic [31:0] opb_q;
   logic        neg_q;

   logic        a_neg, b_neg;
   logic [31:0] mag_a, mag_b;

   logic [32:0] mul_sum;
   logic [63:0] mul_nxt, mul_res;

`ifdef MD_CTRL_DIV_EN
   logic        rneg_q, dz_q;
   logic [31:0] src1_q;
   logic [32:0] div_r, div_diff;
   logic [63:0] div_nxt;
   logic [31:0] div_q_res, div_r_res;
`endif

   assign md_ready = (state_q == S_IDLE) | (state_q == S_DONE);
   assign md_busy  = (state_q == S_MUL) | (state_q == S_DIV);
   assign md_done  = (state_q == S_DONE);
   assign md_hi    = hi_q;
   assign md_lo    = lo_q;
   assign accept   = md_start & md_ready & ~md_cancel;

   // Operand magnitudes; md_op[0]=0 selects the signed variants.
   always_comb begin
      a_neg = ~md_op[0] & md_src1[31];
      b_neg = ~md_op[0] & md_src2[31];
      mag_a = a_neg ? (32'd0 - md_src1) : md_src1;
      mag_b = b_neg ? (32'd0 - md_src2) : md_src2;
   end

   // One shift-add step: add multiplicand when multiplier LSB is set, then
   // shift the 65-bit {carry, acc, multiplier} right by one.
   always_comb begin
      mul_sum = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? opb_q : 32'd0)};
      mul_nxt = {mul_sum, prod_q[31:1]};
      mul_res = neg_q ? (64'd0 - mul_nxt) : mul_nxt;
   end

`ifdef MD_CTRL_DIV_EN
   // One restoring step: shift in the next dividend bit, subtract the divisor
   // and keep the difference only when it did not borrow.
   always_comb begin
      div_r    = {prod_q[63:32], prod_q[31]};
      div_diff = div_r - {1'b0, opb_q};
      if (!div_diff[32]) begin
         div_nxt = {div_diff[31:0], prod_q[30:0], 1'b1};
      end else begin
         div_nxt = {div_r[31:0], prod_q[30:0], 1'b0};
      end
      div_q_res = neg_q  ? (32'd0 - div_nxt[31:0])  : div_nxt[31:0];
      div_r_res = rneg_q ? (32'd0 - div_nxt[63:32]) : div_nxt[63:32];
   end

   assign prod_nxt = (state_q == S_DIV) ? div_nxt : mul_nxt;
`else
   assign prod_nxt = mul_nxt;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (md_cancel) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (md_start) begin
                  state_d = md_op[1] ? S_DIV : S_MUL;
                  cnt_d   = 6'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MUL: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = S_DONE;
                  hi_d    = mul_res[63:32];
                  lo_d    = mul_res[31:0];
               end
            end
            S_DIV: begin
`ifdef MD_CTRL_DIV_EN
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = S_DONE;
                  if (dz_q) begin
                     hi_d = src1_q;
                     lo_d = ZERO_DIV_Q;
                  end else begin
                     hi_d = div_r_res;
                     lo_d = div_q_res;
                  end
               end
`else
               state_d = S_DONE;
               hi_d    = 32'd0;
               lo_d    = 32'd0;
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Datapath registers need no reset: they are always loaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         prod_q <= {32'd0, (md_op[1] ? mag_a : mag_b)};
         opb_q  <= md_op[1] ? mag_b : mag_a;
         neg_q  <= a_neg ^ b_neg;
      end else if (md_busy) begin
         prod_q <= prod_nxt;
      end
   end

`ifdef MD_CTRL_DIV_EN
   always_ff @(posedge clk) begin
      if (accept) begin
         rneg_q <= a_neg;
         dz_q   <= (md_src2 == 32'd0);
         src1_q <= md_src1;
      end
   end
`endif

endmodule
